// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter_ctrl timer/sequencer.
// The COUNTER_CTRL_PRESCALER_EN build also uses DEF_PRESCALE_WIDTH.
package counter_ctrl_pkg;

  localparam int unsigned DEF_WIDTH          = 16;
  localparam int unsigned DEF_PRESCALE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Config/control/status bundle between a register block and counter_ctrl.
// cfg_prescale exists only when COUNTER_CTRL_PRESCALER_EN is defined.
interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
`ifdef COUNTER_CTRL_PRESCALER_EN
  , parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
`endif
);

  logic [WIDTH-1:0] cfg_period;
  logic             cfg_mode;
  logic             start;
  logic             stop;
  logic             hold;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             done;
`ifdef COUNTER_CTRL_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] cfg_prescale;
`endif

`ifdef COUNTER_CTRL_PRESCALER_EN
  modport master (output cfg_period, cfg_mode, cfg_prescale, start, stop, hold,
                  input  busy, cnt, tick, done);
  modport slave  (input  cfg_period, cfg_mode, cfg_prescale, start, stop, hold,
                  output busy, cnt, tick, done);
`else
  modport master (output cfg_period, cfg_mode, start, stop, hold,
                  input  busy, cnt, tick, done);
  modport slave  (input  cfg_period, cfg_mode, start, stop, hold,
                  output busy, cnt, tick, done);
`endif

endinterface

// File: rtl/counter_ctrl_prescaler.sv
// Step-rate divider: strobe once every cfg_prescale+1 enabled cycles.
// Present only in builds with COUNTER_CTRL_PRESCALER_EN defined.
`ifdef COUNTER_CTRL_PRESCALER_EN
module counter_ctrl_prescaler
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      ena,
  input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
  output logic                      strobe
);

  logic [PRESCALE_WIDTH-1:0] pre_q;

  assign strobe = ena && (pre_q == cfg_prescale);

  // Divider holds its phase while disabled; only clr restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (clr) begin
      pre_q <= '0;
    end else if (ena) begin
      pre_q <= strobe ? '0 : pre_q + PRESCALE_WIDTH'(1);
    end
  end

endmodule
`endif

// File: rtl/counter_ctrl.sv
// Programmable one-shot/periodic timer with hold, stop and a registered tick.
// Optional step prescaler enabled by COUNTER_CTRL_PRESCALER_EN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
`ifdef COUNTER_CTRL_PRESCALER_EN
  , parameter int unsigned PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
`endif
) (
  input logic           clk,
  input logic           rst,
  counter_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  mode_t            mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             run_c, strobe_c, step_c, term_c;

  assign run_c  = (state_q == ST_RUN) && !bus.hold;
  assign step_c = run_c && strobe_c;
  assign term_c = step_c && (cnt_q == period_q);

`ifdef COUNTER_CTRL_PRESCALER_EN
  logic [PRESCALE_WIDTH-1:0] prescale_q;

  // Divide ratio is captured once per run, at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
    end else if (bus.start && !bus.stop) begin
      prescale_q <= bus.cfg_prescale;
    end
  end

  counter_ctrl_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .clr          (bus.start || bus.stop),
    .ena          (run_c),
    .cfg_prescale (prescale_q),
    .strobe       (strobe_c)
  );
`else
  assign strobe_c = 1'b1;
`endif

  // Next state/outputs; stop beats start beats terminal count beats step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = done_q;
    busy_d   = 1'b0;
    if (bus.stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (bus.start) begin
      state_d  = ST_RUN;
      cnt_d    = '0;
      done_d   = 1'b0;
      period_d = bus.cfg_period;
      mode_d   = mode_t'(bus.cfg_mode);
    end else if (term_c) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (mode_q == PERIODIC) begin
        period_d = bus.cfg_period;
        mode_d   = mode_t'(bus.cfg_mode);
      end else begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end else if (step_c) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      mode_q   <= ONE_SHOT;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.tick = tick_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed + randomized bench for counter_ctrl against a step-level reference model.
// Adds prescaler checks when COUNTER_CTRL_PRESCALER_EN is defined.
module tb_counter_ctrl;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_ctrl_if bus ();

  counter_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 = stopped, 1 = running, 2 = finished
  int          m_state;
  int unsigned m_cnt, m_period, m_pre, m_ps;
  bit          m_periodic, m_tick, m_done;

  int unsigned os_seq [4] = '{1, 2, 3, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_period = 0; m_pre = 0; m_ps = 0;
    m_periodic = 0; m_tick = 0; m_done = 0;
  endtask

  // One clock edge of the timer, derived from the inputs presented at that edge.
  task automatic model_edge();
    bit stepped;
    m_tick = 0;
    if (bus.stop) begin
      m_state = 0; m_cnt = 0; m_done = 0; m_pre = 0;
    end else if (bus.start) begin
      m_state = 1; m_cnt = 0; m_done = 0; m_pre = 0;
      m_period = 32'(bus.cfg_period);
      m_periodic = bus.cfg_mode;
`ifdef COUNTER_CTRL_PRESCALER_EN
      m_ps = 32'(bus.cfg_prescale);
`endif
    end else if (m_state == 1 && !bus.hold) begin
      stepped = (m_pre == m_ps);
      m_pre = stepped ? 0 : m_pre + 1;
      if (stepped) begin
        if (m_cnt == m_period) begin
          m_cnt = 0;
          m_tick = 1;
          if (m_periodic) begin
            m_period = 32'(bus.cfg_period);
            m_periodic = bus.cfg_mode;
          end else begin
            m_state = 2;
            m_done = 1;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("model_cnt",  32'(bus.cnt),  m_cnt);
    chk("model_tick", 32'(bus.tick), 32'(m_tick));
    chk("model_done", 32'(bus.done), 32'(m_done));
    chk("model_busy", 32'(bus.busy), 32'(m_state == 1));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_period = '0;
    bus.cfg_mode = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.hold = 1'b0;
`ifdef COUNTER_CTRL_PRESCALER_EN
    bus.cfg_prescale = '0;
`endif
    model_reset();
    #12;
    check_model();
    chk("rst_cnt", 32'(bus.cnt), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    rst = 1'b0;
    cycle();

    // One-shot, period 3
    bus.cfg_period = W'(3); bus.cfg_mode = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("os_start_cnt", 32'(bus.cnt), 32'(0));
    chk("os_start_busy", 32'(bus.busy), 32'(1));
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("os_cnt", 32'(bus.cnt), os_seq[k-1]);
      chk("os_tick", 32'(bus.tick), 32'(k == 4));
    end
    chk("os_done", 32'(bus.done), 32'(1));
    chk("os_busy", 32'(bus.busy), 32'(0));
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("os_done_hold", 32'(bus.done), 32'(1));
    end

    // Periodic, period 4 retargeted to 1 mid-count
    bus.cfg_period = W'(4); bus.cfg_mode = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 12) bus.cfg_period = W'(1);
      cycle();
      chk("per_tick", 32'(bus.tick), 32'(k == 5 || k == 10 || k == 15 || k == 17 || k == 19));
    end
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    chk("stop_busy", 32'(bus.busy), 32'(0));

    // Hold for 3 cycles at cnt 2 delays the tick by 3
    bus.cfg_period = W'(5); bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bus.hold = (k >= 3 && k <= 5);
      cycle();
      chk("hold_tick", 32'(bus.tick), 32'(k == 9));
      if (k >= 2 && k <= 5) chk("hold_cnt", 32'(bus.cnt), 32'(2));
    end
    bus.hold = 1'b0;

    // Period 0 ticks on every step
    bus.cfg_period = W'(0); bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      chk("p0_tick", 32'(bus.tick), 32'(1));
      chk("p0_cnt", 32'(bus.cnt), 32'(0));
    end

    // stop and start together: stop wins
    bus.cfg_period = W'(5); bus.stop = 1'b1; bus.start = 1'b1;
    cycle();
    bus.stop = 1'b0; bus.start = 1'b0;
    chk("prio_busy", 32'(bus.busy), 32'(0));
    chk("prio_cnt", 32'(bus.cnt), 32'(0));

    // start on the terminal-count edge restarts without a tick
    bus.cfg_period = W'(2); bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    cycle();
    chk("rs_pre_cnt", 32'(bus.cnt), 32'(2));
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    chk("rs_cnt", 32'(bus.cnt), 32'(0));
    chk("rs_tick", 32'(bus.tick), 32'(0));
    chk("rs_busy", 32'(bus.busy), 32'(1));
    cycle();
    chk("rs_next_cnt", 32'(bus.cnt), 32'(1));

    // Asynchronous reset mid-run at cnt 7
    bus.cfg_period = W'(20); bus.cfg_mode = 1'b0; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    repeat (7) cycle();
    chk("ar_pre_cnt", 32'(bus.cnt), 32'(7));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar_cnt", 32'(bus.cnt), 32'(0));
    chk("ar_busy", 32'(bus.busy), 32'(0));
    chk("ar_tick", 32'(bus.tick), 32'(0));
    chk("ar_done", 32'(bus.done), 32'(0));
    #3;
    rst = 1'b0;
    cycle();
    chk("ar_idle_busy", 32'(bus.busy), 32'(0));
    chk("ar_idle_cnt", 32'(bus.cnt), 32'(0));

`ifdef COUNTER_CTRL_PRESCALER_EN
    // Prescale 2, period 1: count every 3 cycles, tick every 6
    bus.cfg_prescale = 8'd2; bus.cfg_period = W'(1); bus.cfg_mode = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk("ps_cnt", 32'(bus.cnt), 32'((k / 3) % 2));
      chk("ps_tick", 32'(bus.tick), 32'(k == 6 || k == 12));
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      bus.stop  = ($urandom_range(0, 39) == 0);
      bus.hold  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) bus.cfg_period = W'($urandom_range(0, 6));
      bus.cfg_mode = 1'($urandom_range(0, 1));
`ifdef COUNTER_CTRL_PRESCALER_EN
      bus.cfg_prescale = 8'($urandom_range(0, 2));
`endif
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
